vec_pipe_skid: RTL and testbench
================================

VEC_PIPE_SKID -- requirements
Module: vec_pipe_skid

Interface
REQ-001 SHALL have parameter CTRL_WIDTH, default 18, width of the scalar control bundle carried per entry.
REQ-002 SHALL have parameter registerSize, default 8, bits per vector lane.
REQ-003 SHALL have parameter vectorSize, default 4, lanes per vector operand.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of the stall counter.
REQ-005 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 flush  input  1  synchronous discard of all held entries.
REQ-009 in_valid  input  1  upstream entry present.
REQ-010 in_ready  output  1  stage can accept an entry this cycle.
REQ-011 in_ctrl  input  CTRL_WIDTH  control bundle.
REQ-012 in_op1, in_op2  input  vectorSize x registerSize (packed)  vector operands.
REQ-013 out_valid  output  1  downstream entry present.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 out_ctrl, out_op1, out_op2  output  same widths as inputs  head entry.
REQ-016 occupancy  output  2  entries held (0, 1, 2).
REQ-017 stall_cnt  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 SHALL hold at most two entries: main register (drives outputs) and skid register.
REQ-019 State: EMPTY (occupancy 0), ONE (1), FULL (2); occupancy SHALL equal the state encoding.
REQ-020 in_ready SHALL be a registered signal equal to 1 iff state != FULL; it SHALL NOT depend combinationally on out_ready.
REQ-021 Upstream transfer occurs on in_valid & in_ready & !flush; downstream transfer on out_valid & out_ready.
REQ-022 out_valid SHALL be 1 iff state != EMPTY; outputs SHALL come directly from the main register.
REQ-023 Latency: an entry accepted in EMPTY SHALL appear on outputs in the next cycle.
REQ-024 EMPTY: accept -> ONE, entry loads main.
REQ-025 ONE: accept & drain -> ONE, new entry loads main; accept & !drain -> FULL, new entry loads skid; drain & !accept -> EMPTY; neither -> ONE, unchanged.
REQ-026 FULL: drain -> ONE, skid moves to main; !drain -> FULL, unchanged; no accept possible.
REQ-027 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush/rst.
REQ-028 Held outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 flush=1 SHALL set state EMPTY next cycle, discard main and skid, and discard any same-cycle in_valid entry; in_ready SHALL be 1 next cycle.
REQ-030 A same-cycle downstream transfer during flush SHALL complete (consumer sees it); held data is still discarded.
REQ-031 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturating at 2^CNT_WIDTH-1; flush SHALL NOT clear it.
REQ-032 Data registers SHALL load only on a transfer; no enable when idle.

Reset
REQ-033 rst=1 SHALL, next edge, force state EMPTY, out_valid=0, occupancy=0, in_ready=1, stall_cnt=0, main/skid data to 0.
REQ-034 rst SHALL dominate flush and any handshake in the same cycle; mid-operation reset discards all entries.

Verification
REQ-035 After rst, in_valid=1 ctrl=0x00A5 op1 lanes {1,2,3,4}, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x00A5, out_op1={1,2,3,4}, occupancy=1.
REQ-036 out_ready=0, push A then B -> occupancy 2, in_ready=0, out shows A; raise out_ready -> A then B on consecutive cycles, occupancy 1 then 0.
REQ-037 Continuous in_valid=1, out_ready=1, 8 entries 0..7 -> outputs 0..7 one per cycle, in_ready never drops, stall_cnt=0.
REQ-038 FULL with A,B, assert flush with in_valid=1 entry C -> next cycle occupancy 0, out_valid=0, in_ready=1; C never appears.
REQ-039 CNT_WIDTH=4, out_valid=1 out_ready=0 for 20 cycles -> stall_cnt=15 and holds; rst -> 0.
REQ-040 rst asserted in FULL with out_ready=1 -> no further outputs, all outputs at reset values next cycle.

Source files
------------

// File: rtl/vec_pipe_skid.sv
// Two-entry skid buffer for vector operand bundles: a main register drives the
// outputs directly, a skid register catches one extra entry so in_ready can be registered.
module vec_pipe_skid #(
    parameter int CTRL_WIDTH   = 18,
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CTRL_WIDTH-1:0]              in_ctrl,
    input  logic [vectorSize*registerSize-1:0] in_op1,
    input  logic [vectorSize*registerSize-1:0] in_op2,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic [vectorSize*registerSize-1:0] out_op1,
    output logic [vectorSize*registerSize-1:0] out_op2,
    output logic [1:0]                         occupancy,
    output logic [CNT_WIDTH-1:0]               stall_cnt
);

    localparam int OP_W  = vectorSize * registerSize;
    localparam int ENT_W = CTRL_WIDTH + 2 * OP_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [ENT_W-1:0]     main_q, main_d;
    logic [ENT_W-1:0]     skid_q, skid_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [ENT_W-1:0]     in_entry;
    logic                 accept;
    logic                 drain;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    assign in_entry = {in_ctrl, in_op1, in_op2};
    assign accept   = in_valid & in_ready_q & ~flush;
    assign drain    = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A drain during flush still completes downstream; only the held entries vanish.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        if (out_valid && !out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end

        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;
    assign out_ctrl  = main_q[ENT_W-1 -: CTRL_WIDTH];
    assign out_op1   = main_q[2*OP_W-1 -: OP_W];
    assign out_op2   = main_q[OP_W-1:0];

endmodule

// File: tb/tb_vec_pipe_skid.sv
// Directed bench for vec_pipe_skid; stall counter narrowed to 4 bits to reach saturation quickly.
module tb_vec_pipe_skid;

    localparam int CW  = 18;
    localparam int OPW = 32;
    localparam int NW  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [CW-1:0]  in_ctrl = '0;
    logic [OPW-1:0] in_op1 = '0;
    logic [OPW-1:0] in_op2 = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [CW-1:0]  out_ctrl;
    logic [OPW-1:0] out_op1;
    logic [OPW-1:0] out_op2;
    logic [1:0]     occupancy;
    logic [NW-1:0]  stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    vec_pipe_skid #(
        .CTRL_WIDTH  (CW),
        .registerSize(8),
        .vectorSize  (4),
        .CNT_WIDTH   (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_op1   (in_op1),
        .in_op2   (in_op2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_op1  (out_op1),
        .out_op2  (out_op2),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_op1   = {4{c[7:0]}};
        in_op2   = ~{4{c[7:0]}};
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        check("rst_ctrl", 64'(out_ctrl), 64'd0);

        // single entry, one-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 18'h000A5;
        in_op1    = 32'h04030201;
        in_op2    = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_ctrl", 64'(out_ctrl), 64'h0A5);
        check("lat_op1", 64'(out_op1), 64'h04030201);
        check("lat_op2", 64'(out_op2), 64'hDEADBEEF);
        check("lat_occ", 64'(occupancy), 64'd1);
        step();
        check("lat_drained_occ", 64'(occupancy), 64'd0);

        // fill to FULL with A,B while stalled, then drain in order
        out_ready = 1'b0;
        push(18'h011);
        check("fill_occ1", 64'(occupancy), 64'd1);
        push(18'h022);
        check("fill_occ2", 64'(occupancy), 64'd2);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_head", 64'(out_ctrl), 64'h011);
        step();
        check("hold_ctrl", 64'(out_ctrl), 64'h011);
        check("hold_op1", 64'(out_op1), 64'h11111111);
        check("hold_stall", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        step();
        check("drain_b_ctrl", 64'(out_ctrl), 64'h022);
        check("drain_b_op2", 64'(out_op2), 64'hDDDDDDDD);
        check("drain_b_occ", 64'(occupancy), 64'd1);
        check("drain_b_in_ready", 64'(in_ready), 64'd1);
        step();
        check("drain_empty_occ", 64'(occupancy), 64'd0);
        check("drain_empty_valid", 64'(out_valid), 64'd0);

        // streaming 0..7 at full rate
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready_pre", 64'(in_ready), 64'd1);
            push(18'(i));
            check("stream_ctrl", 64'(out_ctrl), 64'(i));
            check("stream_valid", 64'(out_valid), 64'd1);
        end
        step();
        check("stream_stall", 64'(stall_cnt), 64'd0);
        check("stream_occ", 64'(occupancy), 64'd0);

        // flush in FULL discards held entries and the concurrent input
        out_ready = 1'b0;
        push(18'h033);
        push(18'h044);
        check("pre_flush_occ", 64'(occupancy), 64'd2);
        in_valid = 1'b1;
        in_ctrl  = 18'h055;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("flush_no_c", 64'(out_valid), 64'd0);
        push(18'h066);
        check("post_flush_ctrl", 64'(out_ctrl), 64'h066);

        // stall counter saturation at 4 bits
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        push(18'h077);
        for (int i = 0; i < 20; i++) step();
        check("sat_stall", 64'(stall_cnt), 64'd15);
        step();
        check("sat_hold", 64'(stall_cnt), 64'd15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("sat_rst", 64'(stall_cnt), 64'd0);

        // reset in FULL with downstream ready
        out_ready = 1'b0;
        push(18'h0AA);
        push(18'h0BB);
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_stall", 64'(stall_cnt), 64'd0);
        check("mid_rst_ctrl", 64'(out_ctrl), 64'd0);
        check("mid_rst_op1", 64'(out_op1), 64'd0);
        step();
        check("mid_rst_no_b", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
